// File: rtl/vt52_char_writer_if.sv
// Host byte stream into the VT52 character writer.
// Valid/ready handshake; one byte per accepting edge.
interface vt52_char_writer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/vt52_char_writer.sv
// VT52 subset interpreter writing into the shared char buffer.
// Handles cursor motion, direct addressing, erase and scroll-by-copy.
module vt52_char_writer #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  vt52_char_writer_if.slave    in_if,
  output logic [COL_BITS-1:0]  cursor_x,
  output logic [ROW_BITS-1:0]  cursor_y,
  output logic                 buf_wr_en,
  output logic [ADDR_BITS-1:0] buf_wr_addr,
  output logic [7:0]           buf_wr_data,
  output logic [ADDR_BITS-1:0] buf_rd_addr,
  input  logic [7:0]           buf_rd_data
);

  localparam int CELLS = ROWS * COLS;
  localparam int COPY  = (ROWS - 1) * COLS;
  localparam int CW    = ADDR_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ESC,
    S_YROW,
    S_YCOL,
    S_CLEAR,
    S_SCROLL
  } state_t;

  state_t               state_q, state_d;
  logic [COL_BITS-1:0]  x_q, x_d;
  logic [ROW_BITS-1:0]  y_q, y_d;
  logic [7:0]           r_q, r_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS-1:0] end_q, end_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;

  logic       take;
  logic [7:0] bc;
  int         xi;
  int         yi;
  int         cur;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  assign in_if.in_ready = (state_q == S_IDLE) ||
                          (state_q == S_ESC)  ||
                          (state_q == S_YROW) ||
                          (state_q == S_YCOL);
  assign take = in_if.in_valid & in_if.in_ready;
  assign bc   = in_if.in_data - 8'h20;

  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign buf_wr_en   = wr_en_q;
  assign buf_wr_addr = wr_addr_q;
  assign buf_wr_data = wr_data_q;
  assign buf_rd_addr = rd_addr_q;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    r_d       = r_q;
    ptr_d     = ptr_q;
    end_d     = end_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    xi        = int'(x_q);
    yi        = int'(y_q);
    cur       = yi * COLS + xi;
    unique case (state_q)
      S_IDLE: if (take) begin
        if (in_if.in_data >= 8'h20 && in_if.in_data <= 8'h7E) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_BITS'(cur);
          wr_data_d = in_if.in_data;
          x_d       = COL_BITS'(imin(xi + 1, COLS - 1));
        end else begin
          unique case (in_if.in_data)
            8'h0D: x_d = '0;
            8'h0A: begin
              if (yi < ROWS - 1) begin
                y_d = ROW_BITS'(yi + 1);
              end else begin
                state_d   = S_SCROLL;
                cnt_d     = '0;
                rd_addr_d = ADDR_BITS'(COLS);
              end
            end
            8'h08: x_d = COL_BITS'(imax(xi - 1, 0));
            8'h09: x_d = COL_BITS'(imin((xi | 7) + 1, COLS - 1));
            8'h1B: state_d = S_ESC;
            default: ;
          endcase
        end
      end
      S_ESC: if (take) begin
        state_d = S_IDLE;
        unique case (in_if.in_data)
          8'h41: y_d = ROW_BITS'(imax(yi - 1, 0));
          8'h42: y_d = ROW_BITS'(imin(yi + 1, ROWS - 1));
          8'h43: x_d = COL_BITS'(imin(xi + 1, COLS - 1));
          8'h44: x_d = COL_BITS'(imax(xi - 1, 0));
          8'h48: begin
            x_d = '0;
            y_d = '0;
          end
          8'h4A: begin
            state_d = S_CLEAR;
            ptr_d   = ADDR_BITS'(cur);
            end_d   = ADDR_BITS'(CELLS - 1);
          end
          8'h4B: begin
            state_d = S_CLEAR;
            ptr_d   = ADDR_BITS'(cur);
            end_d   = ADDR_BITS'(yi * COLS + COLS - 1);
          end
          8'h59: state_d = S_YROW;
          default: ;
        endcase
      end
      S_YROW: if (take) begin
        r_d     = bc;
        state_d = S_YCOL;
      end
      S_YCOL: if (take) begin
        y_d     = ROW_BITS'(imin(int'(r_q), ROWS - 1));
        x_d     = COL_BITS'(imin(int'(bc), COLS - 1));
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = 8'h20;
        ptr_d     = ptr_q + ADDR_BITS'(1);
        if (ptr_q == end_q) state_d = S_IDLE;
      end
      S_SCROLL: begin
        // read runs one word ahead; write lands on cnt-1
        if (int'(cnt_q) + 1 < COPY)
          rd_addr_d = ADDR_BITS'(COLS + int'(cnt_q) + 1);
        if (cnt_q >= CW'(1)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_BITS'(cnt_q - CW'(1));
          wr_data_d = (cnt_q <= CW'(COPY)) ? buf_rd_data : 8'h20;
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(CELLS)) begin
          state_d = S_IDLE;
          y_d     = ROW_BITS'(ROWS - 1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      x_q       <= '0;
      y_q       <= '0;
      r_q       <= '0;
      ptr_q     <= '0;
      end_q     <= ADDR_BITS'(CELLS - 1);
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      r_q       <= r_d;
      ptr_q     <= ptr_d;
      end_q     <= end_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule
